// File: rtl/io_pkg.sv
// Shared types and defaults for the processor input-port front end.
// The handshake state encoding is fixed so debug taps read the same everywhere.
package io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESENT  = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_e;

  localparam int IO_WIDTH = 8;
  localparam int IO_DEPTH = 4;

endpackage

// File: rtl/input_port_fifo_if.sv
// Producer-side and processor-side signals of the input-port front end.
// Handshakes: a producer byte moves on a cycle where src_valid && src_ready; a processor
// byte is offered while in_dev_hs=1 and is consumed by the first sampled in_dev_ack=1,
// after which in_dev_ack must return low before another byte can be offered.
interface input_port_fifo_if
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
);

  logic [WIDTH-1:0]           src_data;
  logic                       src_valid;
  logic                       src_ready;
  logic                       in_dev_ack;
  logic                       in_dev_hs;
  logic [WIDTH-1:0]           input_bus;
  logic [$clog2(DEPTH+1)-1:0] fill;
  logic                       ovf;
  logic                       ovf_clr;

  modport slave (
    input  src_data, src_valid, in_dev_ack, ovf_clr,
    output src_ready, in_dev_hs, input_bus, fill, ovf
  );

  modport master (
    output src_data, src_valid, in_dev_ack, ovf_clr,
    input  src_ready, in_dev_hs, input_bus, fill, ovf
  );

endinterface

// File: rtl/byte_fifo.sv
// Small power-of-two circular buffer with occupancy count and async active-low clear.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign full  = (fill == FW'(DEPTH));
  assign empty = (fill == '0);
  assign head  = mem[rd_ptr];

  // Storage needs no reset: only entries counted by fill are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/input_port_fifo.sv
// Buffers producer bytes and offers them to the processor one at a time over the
// four-phase in_dev_hs/in_dev_ack handshake; tracks dropped bytes in a sticky flag.
module input_port_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic                   g_clk,
  input  logic                   g_clr,
  input_port_fifo_if.slave       bus,
  output state_e                 state_dbg
);

  state_e           state;
  state_e           state_nxt;
  logic             load;
  logic             pop;
  logic             push;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] bus_q;

  // Push decision uses the pre-edge full flag, so a same-cycle pop never frees a slot early.
  assign push = bus.src_valid && !full;

  byte_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (g_clk),
    .rst_n     (g_clr),
    .push      (push),
    .push_data (bus.src_data),
    .pop       (pop),
    .head      (head),
    .fill      (bus.fill),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !bus.in_dev_ack) begin
          load      = 1'b1;
          state_nxt = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (bus.in_dev_ack) begin
          pop       = 1'b1;
          state_nxt = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        if (!bus.in_dev_ack) begin
          if (!empty) begin
            load      = 1'b1;
            state_nxt = ST_PRESENT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Registered presentation keeps input_bus stable for the whole PRESENT phase.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr)    bus_q <= '0;
    else if (load) bus_q <= head;
  end

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr)                            bus.ovf <= 1'b0;
    else if (bus.src_valid && full)        bus.ovf <= 1'b1;
    else if (bus.ovf_clr)                  bus.ovf <= 1'b0;
  end

  assign bus.src_ready = !full;
  assign bus.in_dev_hs = (state == ST_PRESENT);
  assign bus.input_bus = bus_q;
  assign state_dbg     = state;

endmodule
